// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_search_ctrl
// Purpose  : Successive-approximation search engine for a one-hot magnitude
//            comparator. Drives a probe onto the comparator B operand and
//            narrows in on the unknown target on the A operand. It issues one
//            probe per clock, exits early on equality and flags
//            comparator responses that are not one-hot.
// Ports    : clk, rst_n            clock, synchronous active-low reset
//            start, abort          begin a search / cancel a running one
//            cmp_eq/gt/lt          comparator relation (target vs guess)
//            guess[WIDTH]          registered probe value to comparator B
//            busy, done            search running / one-cycle completion pulse
//            found, err, result    outcome, held until the next start
// Options  : SAR_CMP_REG_EN - comparator outputs are registered (one cycle
//            behind guess). Each probe then waits one settle cycle before the
//            relation is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_msb     = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDXW-1:0]  c_idx_max = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef SAR_CMP_REG_EN
  // High during the cycle the registered comparator is catching up with guess.
  logic             settle_q, settle_d;
`endif

  logic             one_hot;
  logic [WIDTH-1:0] acc_nxt;
  logic [IDXW-1:0]  idx_dec;

  always_comb begin
    one_hot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
              ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
              ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
    // A "greater" answer means the probed bit belongs in the result.
    acc_nxt  = cmp_gt ? guess_q : acc_q;
    idx_dec  = idx_q - 1'b1;

    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
`ifdef SAR_CMP_REG_EN
    settle_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // abort beats start when both arrive in IDLE.
        if (start && !abort) begin
          state_d  = S_PROBE;
          acc_d    = '0;
          idx_d    = c_idx_max;
          guess_d  = c_msb;
          busy_d   = 1'b1;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
`ifdef SAR_CMP_REG_EN
          settle_d = 1'b1;
`endif
        end
      end

      S_PROBE, S_VERIFY: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          guess_d  = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
`ifdef SAR_CMP_REG_EN
        end else if (settle_q) begin
          settle_d = 1'b0;
`endif
        end else if (state_q == S_VERIFY) begin
          // Final confirmation of the fully built value (e.g. target 0).
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = guess_q;
          found_d  = one_hot && cmp_eq;
          err_d    = !(one_hot && cmp_eq);
        end else if (!one_hot) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = acc_q;
        end else if (cmp_eq) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          found_d  = 1'b1;
          result_d = guess_q;
        end else begin
          acc_d = acc_nxt;
          if (idx_q == '0) begin
            guess_d = acc_nxt;
            state_d = S_VERIFY;
          end else begin
            idx_d   = idx_dec;
            guess_d = acc_nxt | (c_one << idx_dec);
          end
`ifdef SAR_CMP_REG_EN
          settle_d = 1'b1;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      guess_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef SAR_CMP_REG_EN
      settle_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef SAR_CMP_REG_EN
      settle_q <= settle_d;
`endif
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Initiator-side controller for the team's 4-bit magnitude comparator (equal / greater / less, one-hot).
- Drives the comparator's B operand with a successive-approximation probe sequence and consumes its relation outputs.
- Recovers an unknown target value applied to the comparator's A operand.
- Used as a built-in search/calibration engine: one probe per clock, early exit on equality, detection of non-one-hot comparator responses.

Parameters:
WIDTH, 4, operand width in bits; probe/result width; max probes = WIDTH+1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
start  input  1  begin a search when idle; ignored while busy
abort  input  1  synchronous cancel; returns to IDLE without done
cmp_eq  input  1  comparator: target == guess
cmp_gt  input  1  comparator: target > guess
cmp_lt  input  1  comparator: target < guess
guess  output  WIDTH  registered probe value driven to comparator B operand
busy  output  1  high while in PROBE or VERIFY
done  output  1  one-cycle pulse at search completion
found  output  1  result valid and confirmed equal; held until next start
err  output  1  comparator response was not one-hot, or VERIFY mismatch; held until next start
result  output  WIDTH  recovered value; held until next start

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; guess=0, busy=0, done=0, found=0, err=0, result=0. Reset overrides start/abort. Mid-search reset clears everything; no done.
- Internal registers: acc[WIDTH-1:0], idx (bit index, 0..WIDTH-1).
- States: IDLE, PROBE, VERIFY.
- IDLE:
  - start=1 → PROBE; acc=0; idx=WIDTH-1; guess=1<<(WIDTH-1); busy=1; found=0, err=0, result=0.
- PROBE:
  - Each edge samples cmp_* against the current guess (comparator is combinational from guess).
  - Not exactly one of eq/gt/lt high → err=1, found=0, result=acc, done=1, → IDLE.
  - eq → found=1, result=guess, done=1, → IDLE.
  - gt → acc'=guess.
  - lt → acc'=acc.
  - If idx==0 → guess=acc', → VERIFY. Else idx--, guess=acc'|(1<<(idx-1)).
- VERIFY (reached only when no eq seen, e.g. target 0):
  - eq → found=1, result=guess.
  - gt/lt or non-one-hot → err=1, found=0, result=guess.
  - Either case: done=1, → IDLE.
- done: registered, high exactly one cycle. busy drops in the same cycle done rises.
- start while busy: ignored. start in the cycle done is high: accepted (back-to-back searches).
- abort while busy: → IDLE, busy=0, guess=0, no done, found/err/result=0. abort in IDLE: no effect. abort and start in the same cycle in IDLE: abort wins, stays IDLE.
- Latency (start sampled at edge 0): probe k sampled at edge k. Equality at probe k → done high after edge k. Worst case WIDTH+1 probes (edge WIDTH+1).
- guess changes only on edges; it is stable for the full cycle in which it is sampled.

Optional Feature:
- Macro: SAR_CMP_REG_EN.
- Defined: the comparator outputs are treated as registered, one cycle behind guess.
  - Each probe takes two cycles: drive guess, then a WAIT cycle before sampling. WAIT is an internal sub-state; busy stays high.
  - Worst-case latency 2*(WIDTH+1).
  - abort and reset behave the same during WAIT.
- Undefined: single-cycle probe as described in Behaviour.

Test Plan:
- Bench comparator model for all scenarios: eq=(T==guess), gt=(T>guess), lt=(T<guess).
- T=11, start → guess 8,12,10,11; done after edge 4; found=1, result=11, err=0.
- T=0 → guess 8,4,2,1 then VERIFY at 0; done after edge 5; found=1, result=0.
- T=15 → guess 8,12,14,15; done after edge 4; result=15. Then start in the done cycle with T=5 → guess 8,4,6,5; result=5.
- Force cmp_eq=1 and cmp_gt=1 at probe 1 → done after edge 1; err=1, found=0, result=0.
- T=9, abort asserted at probe 2 → busy=0 next cycle, no done pulse, guess=0. start pulsed during the search is ignored (probe sequence unchanged).
- Reset mid-search at probe 3 → all outputs 0 next cycle; exhaustive T=0..15 sweep → result==T, found=1 every run, latency ≤5 cycles (≤10 with SAR_CMP_REG_EN).
